// File: rtl/wrap_around_fifo_pkg.sv
// wrap_around_fifo_pkg: shared defaults and pointer-width helper for the wrap-around FIFO
package wrap_around_fifo_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 8;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/wrap_around_fifo_mem.sv
// wrap_around_fifo_mem: FIFO storage, sync write port and enable-gated registered read port
module wrap_around_fifo_mem
  import wrap_around_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  assign rdata_o = rdata_q;
  // storage is never reset; only accepted writes land in the array
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  // output register loads only on an accepted read, otherwise holds its last value
  always_ff @(posedge clk)
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
endmodule

// File: rtl/wrap_around_fifo.sv
// wrap_around_fifo: pointer-based FIFO with wrap bits; WRAP_FIFO_ERR_FLAGS_EN adds overflow/underflow pulses
module wrap_around_fifo
  import wrap_around_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty
`ifdef WRAP_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int AW = PW - 1;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic wr_acc, rd_acc;
  assign empty  = wr_ptr_q == rd_ptr_q;
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  // pointers advance independently on accepted transfers and wrap naturally modulo 2*depth
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end
  // pointer registers; reset discards all stored entries
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  wrap_around_fifo_mem #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q[AW-1:0]),
    .wdata_i(w_data),
    .re_i   (rd_acc),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(r_data)
  );
`ifdef WRAP_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  // one-cycle pulses flagging a dropped write or dropped read
  always_ff @(posedge clk)
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
    end
`endif
endmodule

// File: tb/tb_wrap_around_fifo.sv
// tb_wrap_around_fifo: directed self-checking bench for wrap_around_fifo (DEPTH=8, WIDTH=8)
module tb_wrap_around_fifo;
  logic       clk = 1'b0;
  logic       rst_n, wr_en, rd_en;
  logic [7:0] w_data, r_data;
  logic       full, empty;
`ifdef WRAP_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif
  int errors = 0;
  int checks = 0;

  wrap_around_fifo #(.FIFO_DEPTH(8), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .w_data(w_data),
    .rd_en (rd_en),
    .r_data(r_data),
    .full  (full),
    .empty (empty)
`ifdef WRAP_FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; w_data = 8'h00;
    step(); step();
    rst_n = 1'b1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || r_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: empty=%b full=%b r_data=%h, want empty=1 full=0 r_data=00", empty, full, r_data);
    end
  endtask

  task automatic test_read_empty();
    rd_en = 1'b1; step(); rd_en = 1'b0; step();
    checks++;
    if (empty !== 1'b1 || r_data !== 8'h00) begin
      errors++;
      $display("FAIL read_empty: empty=%b r_data=%h, want empty=1 r_data=00", empty, r_data);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; w_data = 8'h10 + 8'(i);
      step();
      checks++;
      if (full !== (i == 7) || empty !== 1'b0) begin
        errors++;
        $display("FAIL fill[%0d]: full=%b empty=%b, want full=%b empty=0", i, full, empty, i == 7);
      end
    end
    w_data = 8'h99; step(); wr_en = 1'b0;
    checks++;
    if (full !== 1'b1 || r_data !== 8'h00) begin
      errors++;
      $display("FAIL overfill: full=%b r_data=%h, want full=1 r_data=00", full, r_data);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; step();
      checks++;
      if (r_data !== 8'h10 + 8'(i) || full !== 1'b0) begin
        errors++;
        $display("FAIL drain[%0d]: r_data=%h full=%b, want r_data=%h full=0", i, r_data, full, 8'h10 + 8'(i));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: empty=%b, want 1", empty);
    end
    step(); rd_en = 1'b0;
    checks++;
    if (r_data !== 8'h17 || empty !== 1'b1) begin
      errors++;
      $display("FAIL extra_read: r_data=%h empty=%b, want r_data=17 empty=1", r_data, empty);
    end
  endtask

  task automatic test_wrap_simul();
    wr_en = 1'b1; w_data = 8'hA1; step();
    w_data = 8'hA2; step();
    w_data = 8'hA3; rd_en = 1'b1; step();
    wr_en = 1'b0;
    checks++;
    if (r_data !== 8'hA1 || empty !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL simul: r_data=%h empty=%b full=%b, want A1 0 0", r_data, empty, full);
    end
    step();
    checks++;
    if (r_data !== 8'hA2 || empty !== 1'b0) begin
      errors++;
      $display("FAIL wrap_rd1: r_data=%h empty=%b, want A2 0", r_data, empty);
    end
    step(); rd_en = 1'b0;
    checks++;
    if (r_data !== 8'hA3 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_rd2: r_data=%h empty=%b, want A3 1", r_data, empty);
    end
  endtask

  task automatic test_simul_full_empty();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; w_data = 8'hB0 + 8'(i); step();
    end
    w_data = 8'hEE; rd_en = 1'b1; step();
    wr_en = 1'b0;
    checks++;
    if (r_data !== 8'hB0 || full !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: r_data=%h full=%b, want B0 0", r_data, full);
    end
    for (int i = 1; i < 8; i++) begin
      step();
      checks++;
      if (r_data !== 8'hB0 + 8'(i)) begin
        errors++;
        $display("FAIL simul_full_drain[%0d]: r_data=%h, want %h", i, r_data, 8'hB0 + 8'(i));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_full_empty: empty=%b, want 1", empty);
    end
    wr_en = 1'b1; w_data = 8'hC0; step();
    wr_en = 1'b0;
    checks++;
    if (r_data !== 8'hB7 || empty !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty: r_data=%h empty=%b, want B7 0", r_data, empty);
    end
    step(); rd_en = 1'b0;
    checks++;
    if (r_data !== 8'hC0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty_rd: r_data=%h empty=%b, want C0 1", r_data, empty);
    end
  endtask

  task automatic test_mid_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_data = 8'h50 + 8'(i); step();
    end
    wr_en = 1'b0; rd_en = 1'b1; step(); rd_en = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || r_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: empty=%b full=%b r_data=%h, want 1 0 00", empty, full, r_data);
    end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || r_data !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_read: empty=%b r_data=%h, want 1 00", empty, r_data);
    end
  endtask

`ifdef WRAP_FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++;
    if (underflow !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_pulse: underflow=%b overflow=%b, want 1 0", underflow, overflow);
    end
    step();
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: underflow=%b, want 0", underflow);
    end
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_data = 8'(i); step();
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_idle: overflow=%b, want 0", overflow);
    end
    step(); wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pulse: overflow=%b underflow=%b, want 1 0", overflow, underflow);
    end
    step();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: overflow=%b, want 0", overflow);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_empty();
    test_fill();
    test_drain();
    test_wrap_simul();
    test_simul_full_empty();
    test_mid_reset();
`ifdef WRAP_FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
